// File: rtl/mul_share_ctrl_if.sv
// Request/response bundle between the ALU issue logic and the shared
// multiplier sequencer. The issue side is the master, the sequencer the slave.
interface mul_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_signed;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one combinational 32x32->64 unsigned
// multiplier between NUM_REQ requesters. Operands are latched as magnitudes,
// held for MUL_LAT cycles while the adder tree settles, and the sign is
// re-applied to the registered product.

// Combinational unsigned multiplier core (stands in for the adder-tree array).
module mul_share_mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {32'd0, a} * {32'd0, b};
endmodule

module mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_share_ctrl_if.slave     bus,
    output logic                busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cur_id;
    logic [3:0]       cnt;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic             neg;

    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_s;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [63:0]      product;

    // Index base+off reduced modulo NUM_REQ (off is always < NUM_REQ+1).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Round-robin search for the first valid requester at or after ptr.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && bus.req_valid[wrap_add(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
    end

    // Select the winner's operands and mode.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                sel_a = bus.req_a[32*k +: 32];
                sel_b = bus.req_b[32*k +: 32];
                sel_s = bus.req_signed[k];
            end
        end
    end

    // Magnitudes for signed operands; -2^31 maps cleanly to 0x80000000.
    assign abs_a = (sel_s && sel_a[31]) ? (~sel_a + 32'd1) : sel_a;
    assign abs_b = (sel_s && sel_b[31]) ? (~sel_b + 32'd1) : sel_b;

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && grant_vld) bus.req_ready[grant_idx] = 1'b1;
    end

    mul_share_mul32 u_mul (
        .a (mag_a),
        .b (mag_b),
        .p (product)
    );

    // Sequencer FSM with registered response and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset along with the control
        // state, so an aborted product can never be presented after reset.
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            ptr            <= '0;
            cur_id         <= '0;
            cnt            <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            neg            <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        neg    <= sel_s & (sel_a[31] ^ sel_b[31]);
                        cur_id <= grant_idx;
                        ptr    <= wrap_add(grant_idx, 1);
                        cnt    <= 4'(MUL_LAT - 1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_result <= neg ? (~product + 64'd1) : product;
                        bus.rsp_id     <= ID_W'(cur_id);
                        bus.rsp_valid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // At most one requester is granted in any cycle.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    // A stalled response keeps its id and data.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=> ($stable(bus.rsp_result) && $stable(bus.rsp_id)));
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: directed corners, reset abort,
// round-robin fairness and randomized traffic against a behavioural model.
module tb_mul_share_ctrl;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    mul_share_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    mul_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ptr_m    = 0;
    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];
    logic        op_s [NUM_REQ];
    logic [63:0] last_res;
    int          last_id;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a[idx] = a;
        op_b[idx] = b;
        op_s[idx] = s;
        bus.req_a[32*idx +: 32] = a;
        bus.req_b[32*idx +: 32] = b;
        bus.req_signed[idx]     = s;
    endtask

    // Reference product: true signed or unsigned 64-bit multiply.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Reference arbiter: first set bit at or after p, wrapping.
    function automatic int ref_winner(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One complete transaction, entered and left at a falling edge with the DUT idle.
    task automatic do_op(input logic [NUM_REQ-1:0] vmask, input int hold,
                         input bit early, input bit scramble);
        int          g;
        int          lat;
        logic [63:0] exp_res;
        bus.req_valid = vmask;
        #1;
        g = ref_winner(vmask, ptr_m);
        if (g < 0) return;
        check("grant", 64'(bus.req_ready), 64'(1) << g);
        exp_res = ref_mul(op_a[g], op_b[g], op_s[g]);
        @(posedge clk);
        ptr_m = (g + 1) % NUM_REQ;
        @(negedge clk);
        check("busy_calc", 64'(busy), 64'(1));
        check("ready_calc", 64'(bus.req_ready), 64'(0));
        if (early) bus.rsp_ready = 1'b1;
        if (scramble) begin
            for (int k = 0; k < NUM_REQ; k++) set_op(k, $urandom, $urandom, 1'($urandom));
        end
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(MUL_LAT));
        check("rsp_id", 64'(bus.rsp_id), 64'(g));
        check("rsp_result", bus.rsp_result, exp_res);
        last_res = bus.rsp_result;
        last_id  = int'(bus.rsp_id);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 64'(bus.rsp_valid), 64'(1));
                check("hold_result", bus.rsp_result, exp_res);
                check("hold_id", 64'(bus.rsp_id), 64'(g));
                check("hold_ready", 64'(bus.req_ready), 64'(0));
            end
            bus.rsp_ready = 1'b1;
            #1;
            check("no_regrant", 64'(bus.req_ready), 64'(0));
        end
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("valid_drop", 64'(bus.rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
        bus.rsp_ready  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) set_op(k, 32'd0, 32'd0, 1'b0);

        // Reset state, with requests pending that must not be granted.
        rst_n = 1'b0;
        bus.req_valid = '1;
        #12;
        check("rst_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_id", 64'(bus.rsp_id), 64'(0));
        check("rst_result", bus.rsp_result, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(0));
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(bus.req_ready), 64'(0));

        // Directed arithmetic corners.
        set_op(1, 32'd7, 32'd6, 1'b0);
        do_op(4'b0010, 0, 1'b0, 1'b0);
        check("tp_42", last_res, 64'd42);
        check("tp_42_id", 64'(last_id), 64'(1));
        set_op(2, 32'hFFFF_FFFD, 32'd5, 1'b1);
        do_op(4'b0100, 0, 1'b0, 1'b0);
        check("tp_neg15", last_res, 64'hFFFF_FFFF_FFFF_FFF1);
        set_op(3, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op(4'b1000, 5, 1'b0, 1'b0);
        check("tp_uns", last_res, 64'h0000_0004_FFFF_FFF1);
        set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        do_op(4'b0001, 0, 1'b1, 1'b0);
        check("tp_minmin", last_res, 64'h4000_0000_0000_0000);
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(4'b0010, 0, 1'b0, 1'b1);
        check("tp_maxmax", last_res, 64'hFFFF_FFFE_0000_0001);
        set_op(2, 32'd0, 32'hFFFF_FFFB, 1'b1);
        do_op(4'b0100, 1, 1'b0, 1'b0);
        check("tp_zero", last_res, 64'd0);

        // Reset mid-CALC: the aborted product must never appear.
        set_op(3, 32'h0000_1234, 32'h0000_5678, 1'b0);
        bus.req_valid = 4'b1000;
        #1;
        check("abort_grant", 64'(bus.req_ready), 64'(1) << ref_winner(4'b1000, ptr_m));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(bus.rsp_valid), 64'(0));
        check("abort_result", bus.rsp_result, 64'(0));
        check("abort_id", 64'(bus.rsp_id), 64'(0));
        check("abort_ready", 64'(bus.req_ready), 64'(0));
        ptr_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", 64'(bus.rsp_valid), 64'(0));
        end

        // All requesters valid: grants must rotate 0,1,2,3,0.
        for (int k = 0; k < NUM_REQ; k++) set_op(k, $urandom, $urandom, 1'($urandom));
        for (int k = 0; k < 5; k++) begin
            do_op(4'b1111, 0, 1'b0, 1'b0);
            check("rr_id", 64'(last_id), 64'(k % NUM_REQ));
        end

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NUM_REQ; k++) set_op(k, rnd_op(), rnd_op(), 1'($urandom));
            do_op(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
